key_conditioner: RTL and testbench
==================================

# key_conditioner

Multi-channel push-button conditioner that feeds the BCD counter/display stage. It synchronises and debounces raw board keys and emits per-key press/release pulses, a toggle level, and long-press auto-repeat pulses, all in the `clk` domain. It replaces the per-key divided-clock debouncers so that downstream logic runs on `clk` with one-cycle enables instead of key-derived clocks.

## Interface
- `NKEY`, 3: number of key channels.
- `TICK_DIV`, 131072: `clk` cycles per sample tick (about 2.6 ms at 50 MHz).
- `DB_TICKS`, 4: consecutive disagreeing ticks needed to accept a new level.
- `HOLD_TICKS`, 200: ticks of continuous press before the first repeat pulse.
- `REP_TICKS`, 40: ticks between subsequent repeat pulses.

Ports:
- `clk` in 1: single system clock, all logic on its rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `key` in NKEY: raw, asynchronous key inputs. 0 = pressed.
- `level` out NKEY: debounced state. 1 = pressed.
- `press` out NKEY: 1-cycle pulse on accepted press.
- `release` out NKEY: 1-cycle pulse on accepted release.
- `toggle` out NKEY: flips on each accepted press.
- `repeat` out NKEY: 1-cycle auto-repeat pulse while held.
- `tick` out 1: the sample-tick strobe, exported for reuse downstream.

## Operation
- Prescaler:
  - Counter runs 0..TICK_DIV-1, then wraps to 0.
  - `tick` is high for exactly the cycle in which the counter equals TICK_DIV-1.
- Per channel, everything below is independent:
  - **Synchroniser:** two flops on `~key[n]`. The second flop output is `s`.
  - **Debounce:**
    - On a tick with `s == level`: the debounce count clears to 0.
    - On a tick with `s != level`: the count increments.
    - When the count would reach DB_TICKS, `level` takes `s` and the count clears, both on that same edge.
    - Nothing changes between ticks.
  - **Edge outputs:** `press`, `release` and the `toggle` flip are registered on the same edge that updates `level`, so they coincide with the first cycle of the new level.
- Repeat FSM, per channel, with states REL, HOLD and RPT and a tick counter `hc`:
  - REL: `level` rising moves to HOLD with `hc` = 0.
  - HOLD, on each tick: `hc`++. When `hc` would reach HOLD_TICKS, assert `repeat`, move to RPT, and set `hc` = 0.
  - RPT, on each tick: `hc`++. When `hc` would reach REP_TICKS, assert `repeat` and set `hc` = 0.
  - Any state: `level` falling moves to REL and clears `hc`.
- Counter widths are `$clog2` of the respective maximum. No arithmetic overflow is possible because every counter clears at its terminal value.

## Timing
- Reset:
  - Every output is 0.
  - Prescaler, sync flops, debounce counts and `hc` are all 0.
  - FSM is in REL. `toggle` = 0.
- Deassertion of `clr` needs no synchroniser. The first tick is TICK_DIV cycles after release.
- Press latency:
  - 2 cycles for synchronisation, then `level` rises on the DB_TICKS-th tick after `s` changes.
  - Worst case: 2 + DB_TICKS·TICK_DIV cycles.
- A glitch shorter than DB_TICKS consecutive ticks produces no output, and the count restarts.
- The first `repeat` occurs on the HOLD_TICKS-th tick after `press`. Subsequent pulses follow every REP_TICKS ticks.
- Release coinciding with a repeat terminal tick: release wins and no `repeat` is issued.
- `press` and `repeat` are never asserted in the same cycle.
- Simultaneous events on different channels are fully independent, with no arbitration.
- `clr` asserted mid-debounce or mid-hold clears immediately. A key still held after reset must re-debounce and then produces a fresh `press`.

## Structure
- Shared package `key_pkg` holds:
  - default constants for TICK_DIV, DB_TICKS, HOLD_TICKS and REP_TICKS;
  - the FSM state enum `rep_state_t` {REL, HOLD, RPT}.
- Sub-module `key_channel`:
  - one instance per key via generate;
  - contains the synchroniser, debounce logic and repeat FSM;
  - takes `clk`, `clr`, `tick` and a raw key; returns `level`, `press`, `release`, `toggle` and `repeat`.
- The top holds only the prescaler and the generate loop.

## Test plan
Bench parameters: TICK_DIV=4, DB_TICKS=3, HOLD_TICKS=5, REP_TICKS=2, NKEY=3.
- **Reset:** assert `clr` with `key`=3'b000 (all pressed).
  - All outputs stay 0 during reset.
  - After release, `level` is 3'b111 only after 3 ticks.
  - One `press` pulse per key.
- **Clean press:** drive `key[0]`=0 steadily.
  - `level[0]` rises on the 3rd tick after sync.
  - `press[0]` is high exactly 1 cycle on that edge.
  - `toggle[0]` goes 0→1.
  - A second press/release cycle returns `toggle[0]` to 0.
- **Bounce:** `key[1]` low for 2 ticks, high for 1 tick, repeated 5 times, then low steadily.
  - Exactly one `press[1]`, after the steady segment's 3rd tick.
  - No `release[1]`.
- **Auto-repeat:** hold `key[2]` for 15 ticks after `press`.
  - `repeat[2]` at ticks 5, 7, 9, 11, 13, 15 after `press`.
  - Each pulse is 1 cycle.
- **Release vs repeat collision:**
  - Release `key[2]` so `level` falls on the tick at which `repeat` is due: `release[2]` pulses, no `repeat[2]`, FSM in REL.
  - A reset asserted mid-HOLD clears `hc` and gives no stray pulse afterwards.

Source files
------------

// File: rtl/key_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_pkg                                                       |
// | Purpose  : Shared constants, repeat-FSM state type and a counter-width   |
// |            helper for the key conditioner slice.                         |
// | Contents : c_TICK_DIV, c_DB_TICKS, c_HOLD_TICKS, c_REP_TICKS,            |
// |            rep_state_t {REL, HOLD, RPT}, cnt_width()                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package key_pkg;

  localparam int unsigned c_TICK_DIV   = 131072;
  localparam int unsigned c_DB_TICKS   = 4;
  localparam int unsigned c_HOLD_TICKS = 200;
  localparam int unsigned c_REP_TICKS  = 40;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rep_state_t;

  // Width of a counter that holds 0..max_val-1; never narrower than one bit
  // so a terminal count of 1 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_channel                                                   |
// | Purpose  : One key: 2-flop synchroniser, tick-sampled debounce, edge     |
// |            pulses, toggle level and long-press auto-repeat FSM.          |
// | Ports    : clk, clr (async, active high), tick_i (sample strobe),        |
// |            key_i (raw, 0 = pressed) -> level_o, press_o, release_o,      |
// |            toggle_o, repeat_o                                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DB_TICKS   = c_DB_TICKS,
  parameter int unsigned HOLD_TICKS = c_HOLD_TICKS,
  parameter int unsigned REP_TICKS  = c_REP_TICKS
) (
  input  logic clk,
  input  logic clr,
  input  logic tick_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic toggle_o,
  output logic repeat_o
);

  localparam int unsigned DB_W = cnt_width(DB_TICKS);
  localparam int unsigned HC_W = cnt_width((HOLD_TICKS > REP_TICKS) ? HOLD_TICKS : REP_TICKS);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_TICKS - 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_TICKS - 1);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REP_TICKS - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            toggle_q, toggle_d;
  logic            repeat_q, repeat_d;
  rep_state_t      state_q, state_d;
  logic [HC_W-1:0] hc_q, hc_d;

  // Debounce: only tick edges can move the count or the accepted level.
  always_comb begin
    level_d   = level_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        cnt_d     = '0;
        level_d   = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
        toggle_d  = toggle_q ^ sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Repeat FSM. The accepted edges are taken from the debounce decision of
  // the same cycle, so a release on a repeat-terminal tick wins outright and
  // a fresh press always restarts the hold interval without a pulse.
  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    repeat_d = 1'b0;
    if (release_d) begin
      state_d = REL;
      hc_d    = '0;
    end else if (press_d) begin
      state_d = HOLD;
      hc_d    = '0;
    end else if (tick_i) begin
      case (state_q)
        HOLD: begin
          if (hc_q == HOLD_LAST) begin
            repeat_d = 1'b1;
            state_d  = RPT;
            hc_d     = '0;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        RPT: begin
          if (hc_q == REP_LAST) begin
            repeat_d = 1'b1;
            hc_d     = '0;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        default: begin
          state_d = REL;
          hc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
      repeat_q  <= 1'b0;
      state_q   <= REL;
      hc_q      <= '0;
    end else begin
      // Inverted so the synchronised value reads 1 = pressed.
      sync1_q   <= ~key_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
      hc_q      <= hc_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;
  assign repeat_o  = repeat_q;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_conditioner                                               |
// | Purpose  : Multi-key push-button conditioner: shared sample-tick         |
// |            prescaler plus one key_channel per key.                       |
// | Ports    : clk, clr (async, active high), key_i[NKEY] (0 = pressed)      |
// |            -> level_o, press_o, release_o, toggle_o, repeat_o [NKEY],    |
// |            tick_o (sample strobe)                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned NKEY       = 3,
  parameter int unsigned TICK_DIV   = c_TICK_DIV,
  parameter int unsigned DB_TICKS   = c_DB_TICKS,
  parameter int unsigned HOLD_TICKS = c_HOLD_TICKS,
  parameter int unsigned REP_TICKS  = c_REP_TICKS
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NKEY-1:0] key_i,
  output logic [NKEY-1:0] level_o,
  output logic [NKEY-1:0] press_o,
  output logic [NKEY-1:0] release_o,
  output logic [NKEY-1:0] toggle_o,
  output logic [NKEY-1:0] repeat_o,
  output logic            tick_o
);

  localparam int unsigned DIV_W = cnt_width(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_o = (div_q == DIV_LAST);

  generate
    for (genvar n = 0; n < NKEY; n++) begin : g_chan
      key_channel #(
        .DB_TICKS   (DB_TICKS),
        .HOLD_TICKS (HOLD_TICKS),
        .REP_TICKS  (REP_TICKS)
      ) u_chan (
        .clk       (clk),
        .clr       (clr),
        .tick_i    (tick_o),
        .key_i     (key_i[n]),
        .level_o   (level_o[n]),
        .press_o   (press_o[n]),
        .release_o (release_o[n]),
        .toggle_o  (toggle_o[n]),
        .repeat_o  (repeat_o[n])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_key_conditioner                                            |
// | Purpose  : Self-checking bench for key_conditioner with a tick-level     |
// |            behavioural model, directed scenarios and random key traffic. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_key_conditioner;

  localparam int NKEY = 3;
  localparam int TDIV = 4;
  localparam int DB   = 3;
  localparam int HOLD = 5;
  localparam int REP  = 2;

  logic            clk = 1'b0;
  logic            clr;
  logic [NKEY-1:0] key_i;
  logic [NKEY-1:0] level_o, press_o, release_o, toggle_o, repeat_o;
  logic            tick_o;

  always #5 clk = ~clk;

  key_conditioner #(
    .NKEY       (NKEY),
    .TICK_DIV   (TDIV),
    .DB_TICKS   (DB),
    .HOLD_TICKS (HOLD),
    .REP_TICKS  (REP)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .key_i     (key_i),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o),
    .toggle_o  (toggle_o),
    .repeat_o  (repeat_o),
    .tick_o    (tick_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cycles since reset, a two-sample delay line of the
  // pressed state, and per-key counts of ticks in disagreement / ticks held.
  int              m_cyc;
  logic [NKEY-1:0] m_sh1, m_sh2, m_lvl, m_tog, m_prs, m_rel, m_rep;
  int              m_cnt  [NKEY];
  int              m_held [NKEY];

  int cnt_press [NKEY];
  int cnt_rel   [NKEY];
  int cnt_rep   [NKEY];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit t;
    if (clr) begin
      m_cyc = 0;
      m_sh1 = '0; m_sh2 = '0; m_lvl = '0; m_tog = '0;
      m_prs = '0; m_rel = '0; m_rep = '0;
      for (int n = 0; n < NKEY; n++) begin
        m_cnt[n]  = 0;
        m_held[n] = 0;
      end
    end else begin
      t = ((m_cyc % TDIV) == TDIV - 1);
      m_cyc++;
      m_prs = '0; m_rel = '0; m_rep = '0;
      for (int n = 0; n < NKEY; n++) begin
        if (t) begin
          if (m_sh2[n] == m_lvl[n]) begin
            m_cnt[n] = 0;
          end else if (m_cnt[n] + 1 == DB) begin
            m_cnt[n] = 0;
            m_lvl[n] = m_sh2[n];
            if (m_lvl[n]) begin
              m_prs[n]  = 1'b1;
              m_tog[n]  = ~m_tog[n];
              m_held[n] = 0;
            end else begin
              m_rel[n] = 1'b1;
            end
          end else begin
            m_cnt[n]++;
          end
          // Ticks elapsed since the press: first repeat at HOLD, then every REP.
          if (m_lvl[n] && !m_prs[n]) begin
            m_held[n]++;
            if (m_held[n] >= HOLD && ((m_held[n] - HOLD) % REP) == 0)
              m_rep[n] = 1'b1;
          end
        end
      end
      m_sh2 = m_sh1;
      m_sh1 = ~key_i;
    end
  endtask

  task automatic compare_all();
    check("level",   32'(level_o),   32'(m_lvl));
    check("press",   32'(press_o),   32'(m_prs));
    check("release", 32'(release_o), 32'(m_rel));
    check("toggle",  32'(toggle_o),  32'(m_tog));
    check("repeat",  32'(repeat_o),  32'(m_rep));
    check("tick",    32'(tick_o),    32'((m_cyc % TDIV) == TDIV - 1));
    for (int n = 0; n < NKEY; n++) begin
      cnt_press[n] += int'(press_o[n]);
      cnt_rel[n]   += int'(release_o[n]);
      cnt_rep[n]   += int'(repeat_o[n]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic clear_counts();
    for (int n = 0; n < NKEY; n++) begin
      cnt_press[n] = 0;
      cnt_rel[n]   = 0;
      cnt_rep[n]   = 0;
    end
  endtask

  // Steps until press_o[n] is seen, bounded; an expired budget is a failure.
  task automatic wait_press(input int n, input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      found = press_o[n];
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    // Reset with all keys held down.
    clr   = 1'b1;
    key_i = 3'b000;
    steps(4);
    @(negedge clk);
    step();
    clr = 1'b0;
    clear_counts();
    steps(30);
    check("rst_level_all", 32'(level_o), 32'h7);
    check("rst_press0", 32'(cnt_press[0]), 32'd1);
    check("rst_press1", 32'(cnt_press[1]), 32'd1);
    check("rst_press2", 32'(cnt_press[2]), 32'd1);

    // Fresh reset with keys released, then clean press cycles on key 0.
    clr   = 1'b1;
    key_i = 3'b111;
    steps(3);
    clr = 1'b0;
    steps(12);
    clear_counts();
    key_i[0] = 1'b0;
    wait_press(0, 40, "clean_press0_seen");
    check("clean_toggle_up", 32'(toggle_o[0]), 32'd1);
    steps(10);
    key_i[0] = 1'b1;
    steps(30);
    key_i[0] = 1'b0;
    steps(30);
    check("clean_press_cnt", 32'(cnt_press[0]), 32'd2);
    check("clean_rel_cnt",   32'(cnt_rel[0]),   32'd1);
    check("clean_toggle_dn", 32'(toggle_o[0]),  32'd0);
    key_i[0] = 1'b1;
    steps(30);

    // Bounce on key 1: 2 ticks low, 1 tick high, five times, then steady.
    clear_counts();
    for (int r = 0; r < 5; r++) begin
      key_i[1] = 1'b0;
      steps(2 * TDIV);
      key_i[1] = 1'b1;
      steps(TDIV);
    end
    check("bounce_no_press", 32'(cnt_press[1]), 32'd0);
    key_i[1] = 1'b0;
    steps(30);
    check("bounce_press_cnt", 32'(cnt_press[1]), 32'd1);
    check("bounce_no_rel",    32'(cnt_rel[1]),   32'd0);
    key_i[1] = 1'b1;
    steps(30);

    // Auto-repeat on key 2: ticks 5,7,...,15 after press give six pulses.
    key_i[2] = 1'b0;
    wait_press(2, 40, "rep_press_seen");
    clear_counts();
    steps(15 * TDIV);
    check("rep_cnt_15", 32'(cnt_rep[2]), 32'd6);
    // Release so the level falls on tick 19, where a repeat would be due.
    steps(TDIV);
    key_i[2] = 1'b1;
    clear_counts();
    steps(24);
    check("coll_rep_cnt", 32'(cnt_rep[2]), 32'd1);
    check("coll_rel_cnt", 32'(cnt_rel[2]), 32'd1);
    check("coll_level",   32'(level_o[2]), 32'd0);

    // Reset mid-HOLD with the key still held: fresh press, no stray repeat.
    steps(10);
    key_i[2] = 1'b0;
    wait_press(2, 40, "midhold_press_seen");
    steps(2 * TDIV);
    clr = 1'b1;
    steps(3);
    clr = 1'b0;
    clear_counts();
    steps(24);
    check("midhold_press", 32'(cnt_press[2]), 32'd1);
    check("midhold_norep", 32'(cnt_rep[2]),   32'd0);
    steps(20);
    key_i[2] = 1'b1;
    steps(30);

    // Random key traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      for (int n = 0; n < NKEY; n++) begin
        if ($urandom_range(0, 39) == 0) key_i[n] = ~key_i[n];
      end
      clr = ($urandom_range(0, 499) == 0);
      step();
    end
    clr = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
